// File: rtl/dclk_serial_link_pkg.sv
// Shared constants and state types for the bit-serial flit link.
package dclk_serial_link_pkg;

   // Flit composition used by product builds.
   localparam int unsigned HDR_SZ  = 4;
   localparam int unsigned PL_SZ   = 8;
   localparam int unsigned ADDR_SZ = 4;
   localparam int unsigned FLIT_SZ = HDR_SZ + PL_SZ + ADDR_SZ;

   // Line levels: a frame opens with START_BIT, the wire rests at IDLE_LINE.
   localparam logic START_BIT = 1'b1;
   localparam logic IDLE_LINE = 1'b0;

   // Field view of a default-width flit.
   typedef struct packed {
      logic [HDR_SZ-1:0]  hdr;
      logic [PL_SZ-1:0]   pl;
      logic [ADDR_SZ-1:0] addr;
   } flit_t;

   typedef enum logic {
      TX_IDLE,
      TX_SEND
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_RECV,
      RX_HOLD
   } rx_state_t;

endpackage

// File: rtl/dclk_serial_link_if.sv
// Router-side and neighbour-side signals of one serial link.
interface dclk_serial_link_if
   import dclk_serial_link_pkg::*;
#(
   parameter int unsigned FLIT_W = FLIT_SZ
) ();

   logic              req;
   logic [FLIT_W-1:0] parallel_in;
   logic              tx_busy;
   logic              tx_active;
   logic              serial_out;
   logic              channel_busy;
   logic              valid;
   logic [FLIT_W-1:0] parallel_out;
   logic              item_read;

   // Producer/consumer view (router output port and neighbour input port).
   modport master (
      output req, parallel_in, item_read,
      input  tx_busy, tx_active, serial_out, channel_busy, valid, parallel_out
   );

   // The link itself.
   modport slave (
      input  req, parallel_in, item_read,
      output tx_busy, tx_active, serial_out, channel_busy, valid, parallel_out
   );

endinterface

// File: rtl/dclk_ser_tx.sv
// Flit serializer: start bit, then FLIT_W data bits LSB first, then idle.
module dclk_ser_tx
   import dclk_serial_link_pkg::*;
#(
   parameter int unsigned FLIT_W = FLIT_SZ
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_i,
   input  logic [FLIT_W-1:0] data_i,
   input  logic              chan_busy_i,
   output logic              tx_active_o,
   output logic              serial_o
);

   localparam int unsigned CNT_W = $clog2(FLIT_W + 1);

   tx_state_t         state_q, state_d;
   logic [FLIT_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              serial_q, serial_d;
   logic              active_q, active_d;
   logic              accept;
   logic              last_bit;

   // A request is taken only when neither the wire nor the receiver is busy.
   assign accept   = req_i & ~active_q & ~chan_busy_i;
   assign last_bit = (cnt_q == CNT_W'(FLIT_W));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= TX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TX_IDLE: if (accept)   state_d = TX_SEND;
         TX_SEND: if (last_bit) state_d = TX_IDLE;
         default:               state_d = TX_IDLE;
      endcase
   end

   // Output/datapath next values; data register shifts right so bit 0 is always next.
   always_comb begin
      data_d   = data_q;
      cnt_d    = cnt_q;
      serial_d = serial_q;
      active_d = active_q;
      unique case (state_q)
         TX_IDLE: begin
            if (accept) begin
               data_d   = data_i;
               cnt_d    = '0;
               serial_d = START_BIT;
               active_d = 1'b1;
            end
         end
         TX_SEND: begin
            if (last_bit) begin
               serial_d = IDLE_LINE;
               active_d = 1'b0;
            end else begin
               serial_d = data_q[0];
               data_d   = data_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            serial_d = IDLE_LINE;
            active_d = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q   <= '0;
         cnt_q    <= '0;
         serial_q <= IDLE_LINE;
         active_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         serial_q <= serial_d;
         active_q <= active_d;
      end
   end

   assign tx_active_o = active_q;
   assign serial_o    = serial_q;

endmodule

// File: rtl/dclk_serial_link.sv
// Single-clock serial link: serializer feeding an inline deserializer over one wire.
module dclk_serial_link
   import dclk_serial_link_pkg::*;
#(
   parameter int unsigned FLIT_W = FLIT_SZ
) (
   input  logic                clk,
   input  logic                reset,
   dclk_serial_link_if.slave   link
);

   localparam int unsigned CNT_W = $clog2(FLIT_W + 1);

   logic              tx_active;
   logic              serial_bit;
   logic              serial_in;

   rx_state_t         rx_state_q, rx_state_d;
   logic [FLIT_W-1:0] sr_q, sr_d;
   logic [FLIT_W-1:0] pout_q, pout_d;
   logic [CNT_W-1:0]  rcnt_q, rcnt_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              rx_last;

   dclk_ser_tx #(
      .FLIT_W (FLIT_W)
   ) u_tx (
      .clk         (clk),
      .reset       (reset),
      .req_i       (link.req),
      .data_i      (link.parallel_in),
      .chan_busy_i (busy_q),
      .tx_active_o (tx_active),
      .serial_o    (serial_bit)
   );

   // The channel wire loops straight back into the receiver.
   assign serial_in = serial_bit;
   assign rx_last   = (rcnt_q == CNT_W'(FLIT_W - 1));

   // Rx state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state_q <= RX_IDLE;
      end else begin
         rx_state_q <= rx_state_d;
      end
   end

   // Rx next-state logic.
   always_comb begin
      rx_state_d = rx_state_q;
      unique case (rx_state_q)
         RX_IDLE: if (serial_in == START_BIT) rx_state_d = RX_RECV;
         RX_RECV: if (rx_last)                rx_state_d = RX_HOLD;
         RX_HOLD: if (link.item_read)         rx_state_d = RX_IDLE;
         default:                             rx_state_d = RX_IDLE;
      endcase
   end

   // Rx datapath and output next values; busy/valid track the next state.
   always_comb begin
      sr_d   = sr_q;
      pout_d = pout_q;
      rcnt_d = rcnt_q;
      unique case (rx_state_q)
         RX_IDLE: rcnt_d = '0;
         RX_RECV: begin
            sr_d   = {serial_in, sr_q[FLIT_W-1:1]};
            rcnt_d = rcnt_q + CNT_W'(1);
            if (rx_last) pout_d = sr_d;
         end
         default: ;
      endcase
      busy_d  = (rx_state_d != RX_IDLE);
      valid_d = (rx_state_d == RX_HOLD);
   end

   // Rx registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q    <= '0;
         pout_q  <= '0;
         rcnt_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         pout_q  <= pout_d;
         rcnt_q  <= rcnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign link.tx_busy      = tx_active | busy_q;
   assign link.tx_active    = tx_active;
   assign link.serial_out   = serial_bit;
   assign link.channel_busy = busy_q;
   assign link.valid        = valid_q;
   assign link.parallel_out = pout_q;

endmodule

// File: tb/tb_dclk_serial_link.sv
// Directed bench for dclk_serial_link.
module tb_dclk_serial_link;

   localparam int unsigned FW  = 16;
   localparam int          LAT = FW + 1;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   dclk_serial_link_if #(.FLIT_W(FW)) lnk ();

   dclk_serial_link #(.FLIT_W(FW)) dut (
      .clk   (clk),
      .reset (reset),
      .link  (lnk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one flit expecting acceptance, then wait for delivery.
   task automatic send_flit(input logic [FW-1:0] data);
      int lat;
      lnk.req         = 1'b1;
      lnk.parallel_in = data;
      tick();
      lnk.req = 1'b0;
      total++;
      if (lnk.tx_active !== 1'b1 || lnk.serial_out !== 1'b1) begin
         bad++;
         $display("FAIL send_accept data=%h tx_active=%b serial_out=%b required 1/1", data, lnk.tx_active, lnk.serial_out);
      end
      lat = 0;
      while (lnk.valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      total++;
      if (lat !== LAT) begin
         bad++;
         $display("FAIL send_latency data=%h got=%0d required=%0d", data, lat, LAT);
      end
      total++;
      if (lnk.parallel_out !== data) begin
         bad++;
         $display("FAIL send_data got=%h required=%h", lnk.parallel_out, data);
      end
   endtask

   // Consumer acknowledge: valid and channel_busy drop, data is kept.
   task automatic pulse_read();
      logic [FW-1:0] held;
      held           = lnk.parallel_out;
      lnk.item_read  = 1'b1;
      tick();
      lnk.item_read  = 1'b0;
      total++;
      if (lnk.valid !== 1'b0 || lnk.channel_busy !== 1'b0 || lnk.tx_busy !== 1'b0) begin
         bad++;
         $display("FAIL read_clear valid=%b channel_busy=%b tx_busy=%b required 0/0/0", lnk.valid, lnk.channel_busy, lnk.tx_busy);
      end
      total++;
      if (lnk.parallel_out !== held) begin
         bad++;
         $display("FAIL read_keep got=%h required=%h", lnk.parallel_out, held);
      end
   endtask

   task automatic test_reset();
      reset           = 1'b0;
      lnk.req         = 1'b0;
      lnk.parallel_in = '0;
      lnk.item_read   = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      total++;
      if ({lnk.tx_busy, lnk.tx_active, lnk.serial_out, lnk.channel_busy, lnk.valid} !== 5'b0 ||
          lnk.parallel_out !== 16'h0000) begin
         bad++;
         $display("FAIL reset_outputs flags=%b data=%h required 00000/0000",
                  {lnk.tx_busy, lnk.tx_active, lnk.serial_out, lnk.channel_busy, lnk.valid}, lnk.parallel_out);
      end
   endtask

   // Walk one frame bit by bit on the wire.
   task automatic test_single();
      logic [FW-1:0] d;
      d = 16'h0001;
      lnk.req         = 1'b1;
      lnk.parallel_in = d;
      tick();
      lnk.req = 1'b0;
      total++;
      if (lnk.serial_out !== 1'b1 || lnk.tx_active !== 1'b1 || lnk.channel_busy !== 1'b0 || lnk.tx_busy !== 1'b1) begin
         bad++;
         $display("FAIL single_start serial=%b active=%b cbusy=%b tx_busy=%b required 1/1/0/1",
                  lnk.serial_out, lnk.tx_active, lnk.channel_busy, lnk.tx_busy);
      end
      for (int i = 0; i < int'(FW); i++) begin
         tick();
         total++;
         if (lnk.serial_out !== d[i] || lnk.channel_busy !== 1'b1 || lnk.valid !== 1'b0) begin
            bad++;
            $display("FAIL single_bit%0d serial=%b cbusy=%b valid=%b required %b/1/0",
                     i, lnk.serial_out, lnk.channel_busy, lnk.valid, d[i]);
         end
      end
      tick();
      total++;
      if (lnk.valid !== 1'b1 || lnk.parallel_out !== d || lnk.serial_out !== 1'b0 || lnk.tx_active !== 1'b0) begin
         bad++;
         $display("FAIL single_deliver valid=%b data=%h serial=%b active=%b required 1/%h/0/0",
                  lnk.valid, lnk.parallel_out, lnk.serial_out, lnk.tx_active, d);
      end
   endtask

   // Request while the receiver holds an unread flit is dropped.
   task automatic test_drop();
      lnk.req         = 1'b1;
      lnk.parallel_in = 16'h00FF;
      tick();
      lnk.req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (lnk.tx_busy !== 1'b1 || lnk.serial_out !== 1'b0 || lnk.tx_active !== 1'b0 || lnk.parallel_out !== 16'h0001) begin
            bad++;
            $display("FAIL drop_cycle%0d tx_busy=%b serial=%b active=%b data=%h required 1/0/0/0001",
                     i, lnk.tx_busy, lnk.serial_out, lnk.tx_active, lnk.parallel_out);
         end
         tick();
      end
      pulse_read();
      send_flit(16'h00FF);
      pulse_read();
   endtask

   task automatic test_read_idle();
      lnk.item_read = 1'b1;
      tick();
      lnk.item_read = 1'b0;
      tick();
      total++;
      if (lnk.valid !== 1'b0 || lnk.channel_busy !== 1'b0 || lnk.parallel_out !== 16'h00FF) begin
         bad++;
         $display("FAIL read_idle valid=%b cbusy=%b data=%h required 0/0/00FF", lnk.valid, lnk.channel_busy, lnk.parallel_out);
      end
   endtask

   // req and item_read on the same edge: read wins, req refused, next edge accepts.
   task automatic test_simultaneous();
      send_flit(16'hA5C3);
      lnk.req         = 1'b1;
      lnk.parallel_in = 16'h1234;
      lnk.item_read   = 1'b1;
      tick();
      lnk.req       = 1'b0;
      lnk.item_read = 1'b0;
      total++;
      if (lnk.valid !== 1'b0 || lnk.channel_busy !== 1'b0 || lnk.tx_active !== 1'b0 || lnk.serial_out !== 1'b0) begin
         bad++;
         $display("FAIL simul_refuse valid=%b cbusy=%b active=%b serial=%b required 0/0/0/0",
                  lnk.valid, lnk.channel_busy, lnk.tx_active, lnk.serial_out);
      end
      send_flit(16'h1234);
      pulse_read();
   endtask

   // Async reset in the middle of a frame, then a clean transfer.
   task automatic test_reset_mid_frame();
      lnk.req         = 1'b1;
      lnk.parallel_in = 16'h5A5A;
      tick();
      lnk.req = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b0;
      #1;
      total++;
      if ({lnk.tx_busy, lnk.tx_active, lnk.serial_out, lnk.channel_busy, lnk.valid} !== 5'b0 ||
          lnk.parallel_out !== 16'h0000) begin
         bad++;
         $display("FAIL midreset_clear flags=%b data=%h required 00000/0000",
                  {lnk.tx_busy, lnk.tx_active, lnk.serial_out, lnk.channel_busy, lnk.valid}, lnk.parallel_out);
      end
      tick();
      reset = 1'b1;
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         tick();
         total++;
         if (lnk.valid !== 1'b0 || lnk.serial_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset_quiet cycle%0d valid=%b serial=%b required 0/0", i, lnk.valid, lnk.serial_out);
         end
      end
      send_flit(16'h3C96);
      pulse_read();
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] d;
      for (int n = 0; n < 5; n++) begin
         d = FW'($urandom);
         send_flit(d);
         pulse_read();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_drop();
      test_read_idle();
      test_simultaneous();
      test_reset_mid_frame();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
